evolved_netlist_evaluator: RTL and testbench
============================================

Name: evolved_netlist_evaluator

Overview:
- Parametrised, programmable successor to fixed evolved combinational circuits.
- Holds a genome of NUM_GATES two-input gates in registers.
- On start, sweeps all 2^NUM_IN input vectors, evaluating one gate per cycle. It builds the circuit's truth table and scores it against a target, giving a fitness count.
- Sits between the GP genome loader and the fitness/selection logic.

Parameters:
- NUM_IN, 4, number of primary inputs; truth table has 2^NUM_IN rows.
- NUM_GATES, 12, gates in genome; circuit output = output of gate NUM_GATES-1.
- IDX_W, $clog2(NUM_IN+NUM_GATES), width of a signal index.
- GA_W, $clog2(NUM_GATES) (min 1), width of gate address.

Ports:
- clk  in  1  clock; everything on rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_we  in  1  genome write strobe.
- cfg_addr  in  GA_W  gate being written.
- cfg_op  in  3  opcode.
- cfg_src_a  in  IDX_W  operand A signal index.
- cfg_src_b  in  IDX_W  operand B signal index.
- target  in  2^NUM_IN  desired truth table; bit v = output for input vector v.
- start  in  1  begin evaluation.
- busy  out  1  evaluation in progress.
- done  out  1  one-cycle pulse at completion.
- fitness  out  NUM_IN+1  count of rows matching target.
- out_vec  out  2^NUM_IN  truth table produced by the genome.
- cfg_err  out  1  sticky genome error flag; tied 0 unless GENOME_CHECK_EN.

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous and active-high.
- Reset values: busy=0, done=0, fitness=0, out_vec=0, cfg_err=0, state=IDLE; all genome entries = {op AND, src_a 0, src_b 0}.
- Opcodes:
  - 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR.
  - 6 NOT (uses A), 7 BUF (uses A).
  - B is ignored for 6/7.
- Signal index space:
  - 0..NUM_IN-1 = bit i of current vector v (input i = v[i]).
  - NUM_IN+k = output of gate k.
  - Index >= NUM_IN+k, including out-of-range, is a forward/illegal reference and reads 0.
- Genome writes: cfg_we writes entry cfg_addr when state is IDLE. Ignored when busy. cfg_addr >= NUM_GATES is ignored.
- FSM:
  - IDLE -> EVAL when start=1. On that edge: latch target, clear fitness and out_vec, v=0, g=0, busy=1.
  - EVAL, each cycle: compute gate g from the value array and store it; g++.
  - EVAL, when g==NUM_GATES-1: write out_vec[v]=result; fitness += (result==target_l[v]); g=0.
    - If v==2^NUM_IN-1 -> DONE; else v++.
  - DONE: done=1, busy=0 for one cycle -> IDLE.
- Latency: start sampled at edge T. EVAL occupies 2^NUM_IN*NUM_GATES cycles. done is high in cycle T+2^NUM_IN*NUM_GATES+1.
- fitness and out_vec hold their values until the next accepted start or rst.
- start while busy or in DONE is ignored. start on the same cycle as cfg_we in IDLE: the write takes effect and is used by the evaluation.
- Fitness saturation is impossible: the maximum is 2^NUM_IN, which fits in NUM_IN+1 bits.
- Reset mid-evaluation: immediate return to reset values, including genome. No done pulse.

Optional Feature:
- Macro: GENOME_CHECK_EN.
- Defined: an accepted cfg_we with any used operand index >= NUM_IN+cfg_addr sets cfg_err. B is unused for NOT/BUF. cfg_err stays set until rst; the write is still performed.
- Undefined: cfg_err constant 0, no check logic.

Decomposition:
- Package evolved_pkg:
  - opcode enum (3-bit), FSM state enum {IDLE, EVAL, DONE}.
  - gate_t struct {op, src_a, src_b}.
  - Opcode constants.
- Sub-module evolved_gate_alu: purely combinational (op, a, b) -> y. Instantiated once, shared across gates.

Test Plan (NUM_IN=4, NUM_GATES=12):
- Reset: assert rst 2 cycles -> busy=0, done=0, fitness=0, out_vec=16'h0000, cfg_err=0.
- Genome XOR sweep:
  - Program gate0 XOR(src 0, src 1), gates 1..11 BUF(src 4+k-1), target=16'h6666, start.
  - Expect out_vec=16'h6666, fitness=16, done exactly 193 cycles after start edge.
- Same genome, target=16'h9999 -> fitness=0, out_vec=16'h6666.
- Forward reference:
  - Gate0 AND(src 5, src 0), rest BUF chain, target=16'h0000 -> out_vec=0, fitness=16.
  - With GENOME_CHECK_EN: cfg_err=1 after the write, stays 1 until rst.
- Mid-run interference:
  - start accepted; at cycle 20 pulse start again and cfg_we gate0 NOT -> both ignored; result as in XOR sweep.
  - Second run, assert rst at cycle 50 -> busy=0 next cycle, no done pulse, fitness=0.
- Back-to-back: start asserted the cycle after done -> accepted; fitness clears, then recomputes to the same value.

Source files
------------

// File: rtl/evolved_pkg.sv
// Shared types for the evolved netlist evaluator: opcodes, FSM states and genome entry layout.
package evolved_pkg;

   // Genome entries store signal indices at this fixed width; the top zero-extends narrower indices.
   localparam int unsigned IDX_W_MAX = 8;

   typedef enum logic [2:0] {
      OP_AND  = 3'd0,
      OP_OR   = 3'd1,
      OP_NAND = 3'd2,
      OP_NOR  = 3'd3,
      OP_XOR  = 3'd4,
      OP_XNOR = 3'd5,
      OP_NOT  = 3'd6,
      OP_BUF  = 3'd7
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EVAL = 2'd1,
      DONE = 2'd2
   } state_e;

   typedef struct packed {
      op_e                  op;
      logic [IDX_W_MAX-1:0] src_a;
      logic [IDX_W_MAX-1:0] src_b;
   } gate_t;

   localparam gate_t GATE_RESET = '{op: OP_AND, src_a: '0, src_b: '0};

   // True when operand B participates in the gate function.
   function automatic logic uses_b(input op_e op);
      return (op != OP_NOT) && (op != OP_BUF);
   endfunction

endpackage

// File: rtl/evolved_netlist_evaluator_if.sv
// Genome-config / control / result bundle of the evolved netlist evaluator.
interface evolved_netlist_evaluator_if #(
   parameter int unsigned NUM_IN    = 4,
   parameter int unsigned NUM_GATES = 12
);
   localparam int unsigned IDX_W = $clog2(NUM_IN + NUM_GATES);
   localparam int unsigned GA_W  = (NUM_GATES > 1) ? $clog2(NUM_GATES) : 1;
   localparam int unsigned ROWS  = 2 ** NUM_IN;
   localparam int unsigned FW    = NUM_IN + 1;

   logic             cfg_we;
   logic [GA_W-1:0]  cfg_addr;
   logic [2:0]       cfg_op;
   logic [IDX_W-1:0] cfg_src_a;
   logic [IDX_W-1:0] cfg_src_b;
   logic [ROWS-1:0]  target;
   logic             start;
   logic             busy;
   logic             done;
   logic [FW-1:0]    fitness;
   logic [ROWS-1:0]  out_vec;
   logic             cfg_err;

   modport master (
      output cfg_we, cfg_addr, cfg_op, cfg_src_a, cfg_src_b, target, start,
      input  busy, done, fitness, out_vec, cfg_err
   );

   modport slave (
      input  cfg_we, cfg_addr, cfg_op, cfg_src_a, cfg_src_b, target, start,
      output busy, done, fitness, out_vec, cfg_err
   );
endinterface

// File: rtl/evolved_gate_alu.sv
// Two-input gate function shared by all genome entries.
module evolved_gate_alu
   import evolved_pkg::*;
(
   input  op_e  op,
   input  logic a,
   input  logic b,
   output logic y
);

   // Decode opcode into the boolean function of a and b.
   always_comb begin
      y = 1'b0;
      case (op)
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
         OP_NAND: y = ~(a & b);
         OP_NOR:  y = ~(a | b);
         OP_XOR:  y = a ^ b;
         OP_XNOR: y = ~(a ^ b);
         OP_NOT:  y = ~a;
         OP_BUF:  y = a;
         default: y = 1'b0;
      endcase
   end

endmodule

// File: rtl/evolved_netlist_evaluator.sv
// Programmable genome evaluator: sweeps every input vector one gate per cycle,
// builds the truth table of the last gate and counts rows matching the target.
// Optional macro GENOME_CHECK_EN: flags genome writes that reference
// non-earlier signals through the sticky cfg_err output.
module evolved_netlist_evaluator
   import evolved_pkg::*;
#(
   parameter int unsigned NUM_IN    = 4,
   parameter int unsigned NUM_GATES = 12
) (
   input logic                   clk,
   input logic                   rst,
   evolved_netlist_evaluator_if.slave bus
);

   localparam int unsigned IDX_W  = $clog2(NUM_IN + NUM_GATES);
   localparam int unsigned GA_W   = (NUM_GATES > 1) ? $clog2(NUM_GATES) : 1;
   localparam int unsigned ROWS   = 2 ** NUM_IN;
   localparam int unsigned FW     = NUM_IN + 1;
   localparam logic [GA_W-1:0]   LAST_G = GA_W'(NUM_GATES - 1);
   localparam logic [NUM_IN-1:0] LAST_V = NUM_IN'(ROWS - 1);

   state_e               state;
   gate_t                genome [NUM_GATES];
   logic [NUM_GATES-1:0] vals;
   logic [ROWS-1:0]      target_l;
   logic [NUM_IN-1:0]    v;
   logic [GA_W-1:0]      g;
   gate_t                cur;
   logic                 a_val;
   logic                 b_val;
   logic                 alu_y;
   logic                 wr_ok;

   // Resolve a signal index: primary input bit, earlier gate output, or 0 for forward/illegal refs.
   function automatic logic fetch(input logic [IDX_W_MAX-1:0] idx,
                                  input logic [NUM_IN-1:0]    vec,
                                  input logic [GA_W-1:0]      gidx,
                                  input logic [NUM_GATES-1:0] gv);
      logic r;
      r = 1'b0;
      for (int unsigned k = 0; k < NUM_IN; k++)
         if (idx == IDX_W_MAX'(k)) r = vec[k];
      for (int unsigned k = 0; k < NUM_GATES; k++)
         if ((idx == IDX_W_MAX'(NUM_IN + k)) && (GA_W'(k) < gidx)) r = gv[k];
      return r;
   endfunction

   // Operand fetch for the gate being evaluated this cycle.
   always_comb begin
      cur   = genome[g];
      a_val = fetch(cur.src_a, v, g, vals);
      b_val = fetch(cur.src_b, v, g, vals);
   end

   evolved_gate_alu u_alu (
      .op (cur.op),
      .a  (a_val),
      .b  (b_val),
      .y  (alu_y)
   );

   assign wr_ok = (state == IDLE) && bus.cfg_we && (32'(bus.cfg_addr) < NUM_GATES);

   // Control FSM, genome storage and result accumulation.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         bus.busy    <= 1'b0;
         bus.done    <= 1'b0;
         bus.fitness <= '0;
         bus.out_vec <= '0;
         target_l    <= '0;
         v           <= '0;
         g           <= '0;
         vals        <= '0;
         for (int unsigned i = 0; i < NUM_GATES; i++) genome[i] <= GATE_RESET;
      end else begin
         bus.done <= 1'b0;
         case (state)
            IDLE: begin
               if (wr_ok)
                  genome[bus.cfg_addr] <= '{op:    op_e'(bus.cfg_op),
                                           src_a: IDX_W_MAX'(bus.cfg_src_a),
                                           src_b: IDX_W_MAX'(bus.cfg_src_b)};
               if (bus.start) begin
                  state       <= EVAL;
                  target_l    <= bus.target;
                  bus.fitness <= '0;
                  bus.out_vec <= '0;
                  v           <= '0;
                  g           <= '0;
                  bus.busy    <= 1'b1;
               end
            end
            EVAL: begin
               vals[g] <= alu_y;
               if (g == LAST_G) begin
                  g              <= '0;
                  bus.out_vec[v] <= alu_y;
                  bus.fitness    <= bus.fitness + FW'(alu_y == target_l[v]);
                  if (v == LAST_V) state <= DONE;
                  else             v     <= v + 1'b1;
               end else begin
                  g <= g + 1'b1;
               end
            end
            DONE: begin
               bus.done <= 1'b1;
               bus.busy <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef GENOME_CHECK_EN
   logic bad_ref;

   // A used operand must reference a primary input or a strictly earlier gate.
   always_comb begin
      bad_ref = (32'(bus.cfg_src_a) >= NUM_IN + 32'(bus.cfg_addr));
      if (uses_b(op_e'(bus.cfg_op)) && (32'(bus.cfg_src_b) >= NUM_IN + 32'(bus.cfg_addr)))
         bad_ref = 1'b1;
   end

   // Sticky genome error flag, cleared only by reset.
   always_ff @(posedge clk) begin
      if (rst)                   bus.cfg_err <= 1'b0;
      else if (wr_ok && bad_ref) bus.cfg_err <= 1'b1;
   end
`else
   assign bus.cfg_err = 1'b0;
`endif

endmodule

// File: tb/tb_evolved_netlist_evaluator.sv
// Scoreboard bench for evolved_netlist_evaluator (NUM_IN=4, NUM_GATES=12).
module tb_evolved_netlist_evaluator;
   import evolved_pkg::*;

   localparam int unsigned NI = 4;
   localparam int unsigned NG = 12;
   localparam int unsigned EVAL_CYC = 16 * NG + 1;

   typedef struct {
      logic [15:0] out_vec;
      logic [4:0]  fitness;
      int          start_edge;
   } exp_t;

   logic clk;
   logic rst;
   int   cyc;
   int   errors;
   int   checks;
   exp_t q[$];

   evolved_netlist_evaluator_if #(.NUM_IN(NI), .NUM_GATES(NG)) bus ();

   evolved_netlist_evaluator #(.NUM_IN(NI), .NUM_GATES(NG)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!rst && bus.done === 1'b1) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done at cycle %0d", cyc);
         end else begin
            exp_t e;
            e = q.pop_front();
            check("out_vec", 32'(bus.out_vec), 32'(e.out_vec));
            check("fitness", 32'(bus.fitness), 32'(e.fitness));
            check("latency", 32'(cyc - e.start_edge), 32'(EVAL_CYC));
         end
      end
   end

   task automatic write_gate(input int addr, input op_e op, input int a, input int b);
      @(negedge clk);
      bus.cfg_we    = 1'b1;
      bus.cfg_addr  = 4'(addr);
      bus.cfg_op    = op;
      bus.cfg_src_a = 4'(a);
      bus.cfg_src_b = 4'(b);
      @(negedge clk);
      bus.cfg_we    = 1'b0;
   endtask

   task automatic program_chain(input op_e op0, input int a0, input int b0);
      write_gate(0, op0, a0, b0);
      for (int k = 1; k < int'(NG); k++) write_gate(k, OP_BUF, NI + k - 1, 0);
   endtask

   task automatic start_run(input logic [15:0] tgt, input logic expect_done,
                            input logic [15:0] exp_out, input logic [4:0] exp_fit);
      exp_t e;
      @(negedge clk);
      bus.target = tgt;
      bus.start  = 1'b1;
      e.out_vec    = exp_out;
      e.fitness    = exp_fit;
      e.start_edge = cyc + 1;
      if (expect_done) q.push_back(e);
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      while (bus.done !== 1'b1 && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (bus.done !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: done not seen after %0d cycles", name, n);
      end
   endtask

   initial begin
      cyc           = 0;
      errors        = 0;
      checks        = 0;
      rst           = 1'b1;
      bus.cfg_we    = 1'b0;
      bus.cfg_addr  = '0;
      bus.cfg_op    = '0;
      bus.cfg_src_a = '0;
      bus.cfg_src_b = '0;
      bus.target    = '0;
      bus.start     = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_busy",    32'(bus.busy),    32'h0);
      check("rst_done",    32'(bus.done),    32'h0);
      check("rst_fitness", 32'(bus.fitness), 32'h0);
      check("rst_out_vec", 32'(bus.out_vec), 32'h0);
      check("rst_cfg_err", 32'(bus.cfg_err), 32'h0);
      rst = 1'b0;

      // Reset genome: every gate AND(in0,in0), so the output is input bit 0.
      start_run(16'h0000, 1'b1, 16'haaaa, 5'd8);
      wait_done("reset_genome");

      // XOR of inputs 0 and 1 propagated through a buffer chain.
      program_chain(OP_XOR, 0, 1);
      check("xor_cfg_err", 32'(bus.cfg_err), 32'h0);
      start_run(16'h6666, 1'b1, 16'h6666, 5'd16);
      @(negedge clk);
      check("busy_running", 32'(bus.busy), 32'h1);
      wait_done("xor_sweep");
      @(negedge clk);
      check("busy_after_done", 32'(bus.busy), 32'h0);
      check("fitness_hold", 32'(bus.fitness), 32'd16);

      start_run(16'h9999, 1'b1, 16'h6666, 5'd0);
      wait_done("xor_inverse");

      // Forward reference in gate 0 reads as 0.
      write_gate(0, OP_AND, 5, 0);
`ifdef GENOME_CHECK_EN
      check("fwd_cfg_err", 32'(bus.cfg_err), 32'h1);
`else
      check("fwd_cfg_err", 32'(bus.cfg_err), 32'h0);
`endif
      start_run(16'h0000, 1'b1, 16'h0000, 5'd16);
      wait_done("forward_ref");

      // Start and genome write during evaluation are both ignored.
      write_gate(0, OP_XOR, 0, 1);
      start_run(16'h6666, 1'b1, 16'h6666, 5'd16);
      repeat (19) @(negedge clk);
      bus.start     = 1'b1;
      bus.cfg_we    = 1'b1;
      bus.cfg_addr  = 4'd0;
      bus.cfg_op    = OP_NOT;
      bus.cfg_src_a = 4'd0;
      bus.cfg_src_b = 4'd0;
      @(negedge clk);
      bus.start  = 1'b0;
      bus.cfg_we = 1'b0;
      wait_done("interference");
`ifdef GENOME_CHECK_EN
      check("cfg_err_sticky", 32'(bus.cfg_err), 32'h1);
`else
      check("cfg_err_sticky", 32'(bus.cfg_err), 32'h0);
`endif

      // Reset mid-evaluation: abort, no done pulse.
      start_run(16'h6666, 1'b0, 16'h0, 5'd0);
      repeat (48) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_busy",    32'(bus.busy),    32'h0);
      check("midrst_fitness", 32'(bus.fitness), 32'h0);
      check("midrst_out_vec", 32'(bus.out_vec), 32'h0);
      check("midrst_cfg_err", 32'(bus.cfg_err), 32'h0);
      rst = 1'b0;
      repeat (EVAL_CYC + 10) @(negedge clk);
      check("midrst_idle", 32'(bus.busy), 32'h0);

      // Back-to-back: restart on the cycle following done.
      program_chain(OP_XOR, 0, 1);
      start_run(16'h6666, 1'b1, 16'h6666, 5'd16);
      wait_done("b2b_first");
      start_run(16'h6666, 1'b1, 16'h6666, 5'd16);
      check("b2b_fitness_clear", 32'(bus.fitness), 32'h0);
      check("b2b_busy",          32'(bus.busy),    32'h1);
      wait_done("b2b_second");
      repeat (3) @(negedge clk);

      check("queue_drained", 32'(q.size()), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
